// File: rtl/bus_mem_responder.sv
// bus_mem_responder: memory-side responder for the cache line-fill/writeback
// bus. It backs the bus with a 128-bit line store and answers each request
// after a fixed LATENCY. BUS_R, BUS_READ and BUS_ERR are registered. They rise
// on the edge that leaves RESP, which is LATENCY edges after acceptance.
// Optional feature: define BUS_MEM_RANGE_CHK_EN to add the BUS_ERR port. With
// it, requests beyond DEPTH lines are rejected. Without it, the line index
// wraps modulo DEPTH.
module bus_mem_responder #(
   parameter int LATENCY = 4,    // 1..15
   parameter int DEPTH   = 256   // power of two, 2..4096
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         BUS_EN,
   input  logic         BUS_WR,
   input  logic [15:0]  BUS_ADDR,
   input  logic [127:0] BUS_WRITE,
   output logic         BUS_R,
   output logic [127:0] BUS_READ
`ifdef BUS_MEM_RANGE_CHK_EN
   ,
   output logic         BUS_ERR
`endif
);

   localparam int         AW       = $clog2(DEPTH);
   localparam logic [3:0] CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

   typedef enum logic [1:0] {IDLE, BUSY, RESP, DRAIN} state_t;

   state_t         state, state_nxt;
   logic [3:0]     cnt, cnt_nxt;
   logic           wr_q;
   logic [AW-1:0]  idx_q;
   logic [127:0]   data_q;
   logic           oor_q;
   logic           req_oor;
   logic           accept;
   logic           resp_fire;
   logic           mem_we;
   logic [127:0]   read_nxt;
   logic [127:0]   mem [0:DEPTH-1];
   logic           unused_addr;

`ifdef BUS_MEM_RANGE_CHK_EN
   logic           err_q;
   // An out-of-range request is flagged when its line number exceeds the store.
   assign req_oor = (32'(BUS_ADDR[15:4]) >= 32'(DEPTH));
   assign BUS_ERR = err_q;
`else
   // Without range checking, upper address bits are dropped so the index wraps.
   assign req_oor = 1'b0;
`endif

   // The byte-offset bits never matter. The bits above the index matter only for the range check.
   generate
      if (AW < 12) begin : g_unused_hi
         assign unused_addr = ^{BUS_ADDR[3:0], BUS_ADDR[15:AW+4]};
      end else begin : g_unused_lo
         assign unused_addr = ^BUS_ADDR[3:0];
      end
   endgenerate

   assign accept    = (state == IDLE) && BUS_EN;
   assign resp_fire = (state == RESP);
   assign mem_we    = resp_fire && wr_q && !oor_q;

   // Next-state, countdown and next registered-output values.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      state_nxt = state;
      cnt_nxt   = cnt;
      read_nxt  = '0;
      case (state)
         IDLE: begin
            if (BUS_EN) begin
               if (LATENCY == 1) begin
                  state_nxt = RESP;
               end else begin
                  state_nxt = BUSY;
                  cnt_nxt   = CNT_LOAD;
               end
            end
         end
         BUSY: begin
            if (cnt == 4'd0) state_nxt = RESP;
            else             cnt_nxt   = cnt - 4'd1;
         end
         RESP: begin
            state_nxt = DRAIN;
            if (!wr_q && !oor_q) read_nxt = mem[idx_q];
         end
         DRAIN: begin
            if (!BUS_EN) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, counter and output registers. clr overrides everything.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (clr) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         BUS_R    <= 1'b0;
         BUS_READ <= '0;
`ifdef BUS_MEM_RANGE_CHK_EN
         err_q    <= 1'b0;
`endif
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         BUS_R    <= resp_fire;
         BUS_READ <= read_nxt;
`ifdef BUS_MEM_RANGE_CHK_EN
         err_q    <= resp_fire && oor_q;
`endif
      end
   end

   // Capture the request on acceptance. Later bus activity is ignored until the next IDLE.
   always_ff @(posedge clk) begin
      if (accept) begin
         wr_q   <= BUS_WR;
         idx_q  <= BUS_ADDR[AW+3:4];
         data_q <= BUS_WRITE;
         oor_q  <= req_oor;
      end
   end

   // Commit a write on the edge leaving RESP. A clr on that edge discards it.
   always_ff @(posedge clk) begin
      // NOTE: the line store is deliberately not reset; contents survive clr and may be preloaded.
      if (!clr && mem_we) mem[idx_q] <= data_q;
   end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder. dut0 uses LATENCY=4 and dut1 uses
// LATENCY=1, both with DEPTH=256. Lines are preloaded through bus writes.
module tb_bus_mem_responder;

   logic               clk = 1'b0;
   logic               clr;
   logic [1:0]         en, wr;
   logic [1:0][15:0]   addr;
   logic [1:0][127:0]  wdata, rdata;
   logic [1:0]         bus_r, err;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   bus_mem_responder #(.LATENCY(4), .DEPTH(256)) dut0 (
      .clk(clk), .clr(clr), .BUS_EN(en[0]), .BUS_WR(wr[0]), .BUS_ADDR(addr[0]),
      .BUS_WRITE(wdata[0]), .BUS_R(bus_r[0]), .BUS_READ(rdata[0])
`ifdef BUS_MEM_RANGE_CHK_EN
      , .BUS_ERR(err[0])
`endif
   );

   bus_mem_responder #(.LATENCY(1), .DEPTH(256)) dut1 (
      .clk(clk), .clr(clr), .BUS_EN(en[1]), .BUS_WR(wr[1]), .BUS_ADDR(addr[1]),
      .BUS_WRITE(wdata[1]), .BUS_R(bus_r[1]), .BUS_READ(rdata[1])
`ifdef BUS_MEM_RANGE_CHK_EN
      , .BUS_ERR(err[1])
`endif
   );

`ifndef BUS_MEM_RANGE_CHK_EN
   assign err = 2'b00;
`endif

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // One complete transaction. Returns the read data, the error flag and the
   // number of edges from acceptance to the BUS_R rise. It also checks that
   // BUS_R and BUS_READ drop one cycle later. The DUT is back in IDLE on return.
   task automatic do_req(input int s, input logic w, input logic [15:0] a,
                         input logic [127:0] d, output logic [127:0] rd,
                         output logic er, output int lat);
      bit seen;
      @(negedge clk);
      en[s] = 1'b1; wr[s] = w; addr[s] = a; wdata[s] = d;
      @(posedge clk);
      seen = 1'b0; lat = 0; rd = '0; er = 1'b0;
      while (!seen && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (bus_r[s]) begin
            seen = 1'b1;
            rd   = rdata[s];
            er   = err[s];
         end
      end
      if (!seen) check("response_timeout", 128'd0, 128'd1);
      en[s] = 1'b0;
      @(posedge clk); #1;
      check("pulse_end", {127'd0, bus_r[s]}, 128'd0);
      check("read_clear", rdata[s], 128'd0);
   endtask

   initial begin
      logic [127:0] rd;
      logic         er;
      int           lat;
      int           pulses;
      logic [7:0]   lines [4];

      lines[0] = 8'h09; lines[1] = 8'h0A; lines[2] = 8'h10; lines[3] = 8'h23;
      en = '0; wr = '0; addr = '0; wdata = '0;

      // Reset and idle.
      clr = 1'b1;
      repeat (2) @(posedge clk);
      #1 check("reset_r", {127'd0, bus_r[0]}, 128'd0);
      check("reset_read", rdata[0], 128'd0);
      @(negedge clk) clr = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         check("idle_r", {126'd0, bus_r}, 128'd0);
         check("idle_read", rdata[0], 128'd0);
      end

      // Preload lines through bus writes on both instances.
      for (int i = 0; i < 4; i++) begin
         do_req(0, 1'b1, {4'h0, lines[i], 4'h0}, {16{lines[i]}}, rd, er, lat);
         check("preload_lat", 128'(lat), 128'd4);
      end
      do_req(1, 1'b1, 16'h0100, {16{8'h10}}, rd, er, lat);

      // Read fill, LATENCY=4.
      do_req(0, 1'b0, 16'h010B, '0, rd, er, lat);
      check("fill_lat", 128'(lat), 128'd4);
      check("fill_data", rd, {16{8'h10}});

      // Writeback then fill of the same line, plus a neighbouring line.
      do_req(0, 1'b1, 16'h00A0, 128'h1234, rd, er, lat);
      check("wb_read_zero", rd, 128'd0);
      do_req(0, 1'b0, 16'h00A5, '0, rd, er, lat);
      check("wb_then_fill", rd, 128'h1234);
      do_req(0, 1'b0, 16'h0090, '0, rd, er, lat);
      check("neighbour_intact", rd, {16{8'h09}});

      // Held enable: one pulse only, and no second commit with changed data.
      @(negedge clk);
      en[0] = 1'b1; wr[0] = 1'b1; addr[0] = 16'h0300; wdata[0] = 128'hAAAA;
      @(posedge clk);
      pulses = 0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); #1;
         if (bus_r[0]) pulses++;
         if (c == 10) wdata[0] = 128'hBBBB;
      end
      check("held_pulses", 128'(pulses), 128'd1);
      en[0] = 1'b0;
      repeat (2) @(posedge clk);
      do_req(0, 1'b0, 16'h0300, '0, rd, er, lat);
      check("held_single_commit", rd, 128'hAAAA);

      // Reset in BUSY: write aborted, no response, line keeps its value.
      @(negedge clk);
      en[0] = 1'b1; wr[0] = 1'b1; addr[0] = 16'h00A0; wdata[0] = 128'hDEAD;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk) clr = 1'b1;
      @(posedge clk); #1;
      check("clr_r", {127'd0, bus_r[0]}, 128'd0);
      @(negedge clk);
      clr = 1'b0; en[0] = 1'b0;
      pulses = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (bus_r[0]) pulses++;
      end
      check("clr_no_resp", 128'(pulses), 128'd0);
      do_req(0, 1'b0, 16'h00A0, '0, rd, er, lat);
      check("clr_mem_kept", rd, 128'h1234);

      // Address beyond DEPTH lines.
      do_req(0, 1'b0, 16'h1230, '0, rd, er, lat);
`ifdef BUS_MEM_RANGE_CHK_EN
      check("range_err", {127'd0, er}, 128'd1);
      check("range_data", rd, 128'd0);
`else
      check("wrap_err", {127'd0, er}, 128'd0);
      check("wrap_data", rd, {16{8'h23}});
`endif
      do_req(0, 1'b0, 16'h0230, '0, rd, er, lat);
      check("inrange_err", {127'd0, er}, 128'd0);

      // Fill with LATENCY=1.
      do_req(1, 1'b0, 16'h010B, '0, rd, er, lat);
      check("lat1_lat", 128'(lat), 128'd1);
      check("lat1_data", rd, {16{8'h10}});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation time limit reached");
   end

endmodule

// File: doc/bus_mem_responder.md
# bus_mem_responder

Memory-side responder for the cache's line-fill/writeback bus. It receives BUS_EN/BUS_WR/BUS_ADDR/BUS_WRITE from the cache and returns BUS_R/BUS_READ. It backs the bus with an internal 128-bit-wide line store and a configurable fixed access latency. It replaces the ad-hoc memory models in cache benches and serves as the main-memory stand-in for system integration.

## Interface
- LATENCY, 4: cycles from request acceptance to BUS_R; legal range 1..15.
- DEPTH, 256: number of 128-bit lines in the store; power of two, at most 4096.
- clk  in  1  clock; all logic on the rising edge.
- clr  in  1  reset; synchronous and active-high.
- BUS_EN  in  1  request valid; held stable by the requester until BUS_R is seen.
- BUS_WR  in  1  1 = line write (writeback), 0 = line read (fill).
- BUS_ADDR  in  16  byte address; bits [3:0] are ignored; line index = BUS_ADDR[log2(DEPTH)+3:4].
- BUS_WRITE  in  128  write line data.
- BUS_R  out  1  one-cycle response strobe.
- BUS_READ  out  128  read line data; valid only while BUS_R=1 on a read.
- BUS_ERR  out  1  out-of-range strobe; present only with BUS_MEM_RANGE_CHK_EN.

## Operation
- Storage is the array `mem[0:DEPTH-1]` of 128 bits each.
  - Reset does not clear it.
  - Benches may preload it with $readmemh.
- FSM states: IDLE, BUSY, RESP, DRAIN.
- IDLE:
  - If BUS_EN=1, latch BUS_WR, line index, and BUS_WRITE.
  - Go to RESP if LATENCY=1; otherwise go to BUSY with the counter loaded to LATENCY-2.
- BUSY:
  - Decrement the counter each cycle.
  - Go to RESP when the counter is 0 on an edge.
  - Bus inputs are ignored in this state; only latched values are used.
- RESP:
  - BUS_R=1 for exactly this cycle.
  - Read: BUS_READ = mem[latched index].
  - Write: mem[latched index] <= latched data at the edge leaving RESP; BUS_READ stays 0.
  - Next state is DRAIN.
- DRAIN:
  - Stay in DRAIN while BUS_EN=1.
  - Go to IDLE on the first edge that samples BUS_EN=0.
  - This guarantees one request is serviced exactly once.
- BUS_READ is 0 in every state except RESP-on-read.
- Only one outstanding request is allowed; there is no queueing.

## Timing
- Reset values: state=IDLE, counter=0, BUS_R=0, BUS_READ=0, BUS_ERR=0.
- Request sampled at edge E0 → BUS_R high from E0+LATENCY to E0+LATENCY+1.
- Minimum request-to-request spacing: LATENCY+2 cycles.
  - The requester drops BUS_EN in the cycle after BUS_R.
  - The next request is then accepted at the earliest edge after DRAIN→IDLE.
- BUS_EN still high in DRAIN: no new request is accepted; the responder waits indefinitely.
- A read following a write to the same line returns the new data, because the write commits before DRAIN.
- clr=1 at any edge, including mid-BUSY or in RESP:
  - Return to IDLE and force all outputs to 0.
  - A pending write is discarded and mem is unchanged.
- clr takes priority over everything else.

## Configuration
- BUS_MEM_RANGE_CHK_EN defined:
  - Adds the BUS_ERR port.
  - A request with BUS_ADDR[15:4] >= DEPTH gets BUS_ERR=1 together with BUS_R in RESP.
  - Writes are dropped; reads return BUS_READ=0.
- Not defined:
  - No BUS_ERR port.
  - The index is the low log2(DEPTH) bits of BUS_ADDR[15:4], so the address wraps modulo DEPTH lines.

## Test plan
- Reset and idle: assert clr for 2 cycles with BUS_EN=0 → BUS_R=0 and BUS_READ=0 for 10 cycles.
- Read fill:
  - Preload mem[i] = {16{i[7:0]}}, LATENCY=4.
  - Request BUS_EN=1, BUS_WR=0, BUS_ADDR=16'h010B.
  - → BUS_R high exactly on the 4th edge after sampling, BUS_READ=128'h1010…10; BUS_READ=0 one cycle later.
- Writeback then fill:
  - Write BUS_ADDR=16'h00A0, BUS_WRITE=128'h1234.
  - Then read BUS_ADDR=16'h00A5 → BUS_READ=128'h1234.
  - mem[9] (address 0x0090) is unchanged at {16{8'h09}}.
- Held enable: keep BUS_EN=1 for 20 cycles after BUS_R → exactly one BUS_R pulse and no second write commit.
- Reset mid-write:
  - Write 16'h00A0 with data 128'hDEAD; assert clr at E0+2.
  - → no BUS_R, and mem[10] keeps its prior value.
- Range and wrap check, request to BUS_ADDR=16'h1230 with DEPTH=256:
  - With the macro: BUS_ERR=1 with BUS_R, and the read data is 0.
  - Without the macro: the request accesses mem[8'h23].
- Repeat the fill test with LATENCY=1 → BUS_R is asserted on the first edge after sampling.
